// File: rtl/btb_pkg.sv
// Shared encodings for the bimodal BTB: 2-bit direction counter states
// and the values loaded at reset and on allocation.
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

endpackage

// File: rtl/btb_bimodal_if.sv
// Fetch/execute-facing signal bundle of the BTB; the slave modport is the BTB
// side, the master modport is the pipeline side.
interface btb_bimodal_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 32
);
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   paddr;
  logic              pd;
  logic              hit;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred;
  logic [XLEN-1:0]   upd_ptgt;
  logic              inval;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [PERF_W-1:0] branch_cnt;
  logic [PERF_W-1:0] mispred_cnt;

  modport slave (
    input  addr, upd_valid, upd_pc, upd_taken, upd_target, upd_pred, upd_ptgt, inval,
    output paddr, pd, hit, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );

  modport master (
    output addr, upd_valid, upd_pc, upd_taken, upd_target, upd_pred, upd_ptgt, inval,
    input  paddr, pd, hit, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/btb_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
module btb_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST)  ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/btb_bimodal.sv
// Direct-mapped branch target buffer with 2-bit bimodal direction counters,
// misprediction detection and wrap-around performance counters.
module btb_bimodal
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PERF_W  = 32
) (
  input logic         clk,
  input logic         rst,
  btb_bimodal_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr_nxt;
  logic             mispredict;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.addr[1:0], bus.upd_pc[1:0]};

  assign l_idx = bus.addr[IDX_W+1:2];
  assign l_tag = bus.addr[XLEN-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[XLEN-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  always_comb begin
    bus.hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    bus.pd    = bus.hit && ctr_q[l_idx][1];
    bus.paddr = bus.pd ? tgt_q[l_idx] : bus.addr + XLEN'(4);
  end

  always_comb begin
    mispredict = bus.upd_valid &&
                 ((bus.upd_pred != bus.upd_taken) ||
                  (bus.upd_taken && (bus.upd_ptgt != bus.upd_target)));
    bus.mispredict  = mispredict;
    bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
  end

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  btb_ctr2 u_ctr2 (
    .ctr_i   (ctr_q[u_idx]),
    .taken_i (bus.upd_taken),
    .ctr_o   (u_ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (bus.inval) begin
      for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (bus.upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr_nxt;
        if (bus.upd_taken) tgt_q[u_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= bus.upd_target;
        ctr_q[u_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Performance counters keep counting even when inval drops the table write.
  always_comb begin
    branch_cnt_d  = branch_cnt_q  + PERF_W'(bus.upd_valid);
    mispred_cnt_d = mispred_cnt_q + PERF_W'(mispredict);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_bimodal.sv
// Directed self-checking bench for btb_bimodal (8 entries, 4-bit perf counters).
module tb_btb_bimodal;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PERF_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  btb_bimodal_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

  btb_bimodal #(.ENTRIES(8), .XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    bus.upd_pred   = 1'b0;
    bus.upd_ptgt   = '0;
    bus.inval      = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic pred, input logic [31:0] ptgt);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
    bus.upd_pred   = pred;
    bus.upd_ptgt   = ptgt;
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] a, input logic exp_hit,
                      input logic exp_pd, input logic [31:0] exp_paddr);
    bus.addr = a;
    #1;
    checks++;
    if (bus.hit !== exp_hit || bus.pd !== exp_pd || bus.paddr !== exp_paddr) begin
      errors++;
      $display("FAIL %s: hit=%b pd=%b paddr=%h, expected hit=%b pd=%b paddr=%h",
               name, bus.hit, bus.pd, bus.paddr, exp_hit, exp_pd, exp_paddr);
    end
  endtask

  task automatic cnts(input string name, input logic [3:0] exp_b, input logic [3:0] exp_m);
    checks++;
    if (bus.branch_cnt !== exp_b || bus.mispred_cnt !== exp_m) begin
      errors++;
      $display("FAIL %s: branch_cnt=%0d mispred_cnt=%0d, expected %0d %0d",
               name, bus.branch_cnt, bus.mispred_cnt, exp_b, exp_m);
    end
  endtask

  task automatic resolve(input string name, input logic exp_mp, input logic [31:0] exp_rpc);
    checks++;
    if (bus.mispredict !== exp_mp || (exp_mp && bus.redirect_pc !== exp_rpc)) begin
      errors++;
      $display("FAIL %s: mispredict=%b redirect_pc=%h, expected %b %h",
               name, bus.mispredict, bus.redirect_pc, exp_mp, exp_rpc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.addr = 32'h100;
    tick();
    tick();
    rst = 1'b0;
    look("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    cnts("reset_cnts", 4'd0, 4'd0);
    resolve("reset_no_mispredict", 1'b0, 32'h0);
  endtask

  task automatic test_alloc();
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    resolve("alloc_mispredict", 1'b1, 32'h200);
    tick();
    idle();
    cnts("alloc_cnts", 4'd1, 4'd1);
    look("alloc_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
  endtask

  task automatic test_hysteresis();
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    resolve("nt1_mispredict", 1'b1, 32'h104);
    tick();
    idle();
    look("nt1_lookup", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    resolve("nt2_correct", 1'b0, 32'h0);
    tick();
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    tick();
    idle();
    look("nt3_saturated", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    idle();
    look("taken_from_snt", 32'h100, 1'b1, 1'b0, 32'h104);
    cnts("hyst_cnts", 4'd5, 4'd3);
  endtask

  task automatic test_conflict();
    upd(32'h120, 1'b1, 32'h300, 1'b1, 32'h999);
    resolve("wrong_target", 1'b1, 32'h300);
    tick();
    idle();
    look("evicted_0x100", 32'h100, 1'b0, 1'b0, 32'h104);
    look("occupant_0x120", 32'h120, 1'b1, 1'b1, 32'h300);
    upd(32'h120, 1'b1, 32'h300, 1'b1, 32'h300);
    resolve("correct_taken", 1'b0, 32'h0);
    tick();
    idle();
    cnts("conflict_cnts", 4'd7, 4'd4);
  endtask

  task automatic test_back_to_back();
    upd(32'h140, 1'b1, 32'h400, 1'b0, 32'h144);
    look("same_cycle_no_bypass", 32'h140, 1'b0, 1'b0, 32'h144);
    tick();
    idle();
    look("next_cycle_visible", 32'h140, 1'b1, 1'b1, 32'h400);
    cnts("b2b_cnts", 4'd8, 4'd5);
  endtask

  task automatic test_inval();
    upd(32'h160, 1'b1, 32'h500, 1'b1, 32'h500);
    bus.inval = 1'b1;
    tick();
    idle();
    look("inval_0x140", 32'h140, 1'b0, 1'b0, 32'h144);
    look("inval_0x120", 32'h120, 1'b0, 1'b0, 32'h124);
    look("inval_dropped_0x160", 32'h160, 1'b0, 1'b0, 32'h164);
    cnts("inval_cnts", 4'd9, 4'd5);
    upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h184);
    tick();
    idle();
    look("nt_miss_no_alloc", 32'h180, 1'b0, 1'b0, 32'h184);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      upd(32'h1C0, 1'b0, 32'h0, 1'b0, 32'h1C4);
      tick();
    end
    idle();
    cnts("wrap_cnts", 4'd1, 4'd5);
  endtask

  task automatic test_async_reset();
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    tick();
    idle();
    look("pre_rst_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
    cnts("pre_rst_cnts", 4'd2, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    look("async_rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    cnts("async_rst_cnts", 4'd0, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    look("post_rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alloc();
    test_hysteresis();
    test_conflict();
    test_back_to_back();
    test_inval();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_bimodal.md
# btb_bimodal

Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating direction counters, sitting between the fetch stage (lookup) and the execute stage (resolve/update). Supplies the predicted next PC to fetch each cycle, flags mispredictions and the correct redirect PC back to the pipeline, and keeps wrap-around performance counters for resolved branches and mispredictions. Successor to the single-bit, fixed-8-entry BTB: depth and widths are parameters, direction prediction has hysteresis, the table supports bulk invalidation, and reset is explicit.

## Interface
- ENTRIES, 8, table depth; power of two, 2..1024
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden)
- XLEN, 32, PC / target width
- PERF_W, 32, width of each performance counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  XLEN  fetch PC to look up
- paddr  out  XLEN  predicted next fetch PC
- pd  out  1  predicted taken
- hit  out  1  addr found in table (valid and tag match)
- upd_valid  in  1  a branch resolves in execute this cycle (BranchTypeE != 0)
- upd_pc  in  XLEN  PC of the resolving branch
- upd_taken  in  1  actual direction
- upd_target  in  XLEN  actual target (BrNPC)
- upd_pred  in  1  direction predicted for this branch at fetch (pipelined pd)
- upd_ptgt  in  XLEN  paddr produced for this branch at fetch (pipelined)
- inval  in  1  synchronous clear of all valid bits
- mispredict  out  1  flush request for younger instructions
- redirect_pc  out  XLEN  correct next PC when mispredict = 1
- branch_cnt  out  PERF_W  resolved branch count
- mispred_cnt  out  PERF_W  mispredict count

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]. Per entry: valid, tag, target, ctr[1:0].
- Lookup (combinational): hit = valid[idx] & tag match; pd = hit & ctr[idx][1]; paddr = pd ? target[idx] : addr+4 (mod 2^XLEN).
- No write-to-read bypass: a lookup in the same cycle as an update to the same entry sees the pre-update contents.
- Resolve (combinational, gated by upd_valid): mispredict = upd_valid & ((upd_pred != upd_taken) | (upd_taken & upd_ptgt != upd_target)); redirect_pc = upd_taken ? upd_target : upd_pc+4. When upd_valid = 0, mispredict = 0 and redirect_pc is don't-care.
- Update (rising edge, upd_valid = 1), entry at upd_pc index:
  - tag hit: ctr saturating +1 if taken, -1 if not taken (3 stays 3, 0 stays 0); target <= upd_target if taken.
  - miss, taken: allocate — valid <= 1, tag, target <= upd_target, ctr <= 2'b10 (weakly taken); replaces any prior occupant.
  - miss, not taken: no change.
- inval = 1: all valid <= 0 at the edge; wins over a simultaneous update (the update is dropped). Perf counters still count that branch.
- Perf: branch_cnt += 1 per upd_valid cycle; mispred_cnt += 1 per mispredict cycle; both wrap modulo 2^PERF_W.

## Timing
- Lookup and resolve outputs: zero-cycle combinational.
- Table update visible to lookup the cycle after the edge on which upd_valid is sampled.
- Reset (async assert, released synchronously by the environment): valid all 0, ctr all 2'b01 (weakly not taken), tag/target 0, branch_cnt = mispred_cnt = 0. Consequently after reset hit = 0, pd = 0, paddr = addr+4, mispredict = 0.
- Reset asserted mid-update: the update is lost; state is reset values.
- At most one update per cycle; no stall inputs. The pipeline must hold upd_* stable for exactly the one cycle of resolution.

## Structure
- btb_pkg: counter encodings (SNT=0, WNT=1, WT=2, ST=3), CTR_RESET = WNT, CTR_ALLOC = WT.
- Sub-module btb_ctr2: 2-bit saturating counter next-state function (inputs ctr, taken; output next ctr), instantiated once at the update port.
- Table held in flat register arrays (no RAM macro); a reset loop over ENTRIES.

## Test plan
- Reset, addr=0x0000_0100 -> hit=0, pd=0, paddr=0x0000_0104; both perf counters 0.
- Taken update upd_pc=0x100, target=0x200, upd_pred=0 -> mispredict=1, redirect_pc=0x200, mispred_cnt=1; next cycle lookup 0x100 -> hit=1, pd=1, paddr=0x200.
- From WT, three not-taken updates at 0x100 -> ctr 2->1->0->0; pd=0 after first; paddr=0x104; fourth taken update -> ctr=1, still pd=0.
- ENTRIES=8: allocate 0x100 then taken 0x120 (same index, different tag) -> lookup 0x100 hit=0, 0x120 hit=1 paddr=target.
- Same-cycle update and lookup of 0x140 (fresh alloc) -> lookup hit=0 that cycle, hit=1 the next; inval with simultaneous update -> all hit=0 next cycle, branch_cnt still increments.
- PERF_W=4: 17 resolved branches -> branch_cnt wraps to 1; async rst pulse mid-stream -> counters 0 and table empty immediately, without a clock edge.
